// File: rtl/axi_slave_frontend.sv
// AXI4 slave front-end of the AXI-to-APB bridge. It accepts one AW/W or AR burst at a time,
// hands the burst to the APB handler, and returns the B response or the buffered R beats.
module axi_slave_frontend #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   awid_i,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic [3:0]            awlen_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  wlast_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [ID_WIDTH-1:0]   bid_o,
    output logic [1:0]            bresp_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    input  logic [ID_WIDTH-1:0]   arid_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic [3:0]            arlen_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [ID_WIDTH-1:0]   rid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rlast_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic                  wr_trans_o,
    output logic                  rd_trans_o,
    output logic [ADDR_WIDTH-1:0] trans_addr_o,
    output logic [3:0]            burst_len_o,
    output logic [DATA_WIDTH-1:0] trans_data_o,
    input  logic                  fifo_rden_i,
    input  logic                  trans_done_i,
    input  logic                  trans_error_i,
    input  logic [DATA_WIDTH-1:0] read_data_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_ISSUE, WR_WAIT, WR_RESP, RD_ISSUE, RD_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            len_q, len_d;
    logic [4:0]            cnt_q, cnt_d;
    logic                  err_q, err_d, len_err_q, len_err_d, prio_wr_q, prio_wr_d;
    logic                  wr_trans_q, wr_trans_d, rd_trans_q, rd_trans_d, bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;

    logic [DATA_WIDTH-1:0] wf_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH+1:0] rf_mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wf_wr_q, wf_wr_d, wf_rd_q, wf_rd_d, rf_wr_q, rf_wr_d, rf_rd_q, rf_rd_d;
    logic [CW-1:0]         wf_cnt_q, wf_cnt_d, rf_cnt_q, rf_cnt_d;

    logic grant_wr, grant_rd, w_hs, b_hs, r_hs, r_last;
    logic wf_empty, wf_full, wf_push, wf_pop, rf_empty, rf_full, rf_push, rf_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin only matters when both address channels are valid together.
    assign grant_wr  = awvalid_i && (!arvalid_i || prio_wr_q);
    assign grant_rd  = arvalid_i && (!awvalid_i || !prio_wr_q);
    assign awready_o = (state_q == IDLE) && grant_wr;
    assign arready_o = (state_q == IDLE) && grant_rd;
    assign wready_o  = (state_q == WR_DATA);
    assign w_hs      = wvalid_i && wready_o;
    assign b_hs      = bvalid_q && bready_i;

    assign wf_empty = (wf_cnt_q == '0);
    assign wf_full  = (wf_cnt_q == CW'(FIFO_DEPTH));
    assign rf_empty = (rf_cnt_q == '0);
    assign rf_full  = (rf_cnt_q == CW'(FIFO_DEPTH));
    assign wf_push  = w_hs && (cnt_q <= {1'b0, len_q}) && !wf_full;
    assign wf_pop   = fifo_rden_i && !wf_empty;
    assign rf_push  = (state_q == RD_WAIT) && trans_done_i && !rf_full;

    // In RD_WAIT cnt_q counts R beats already sent, so the presented beat is cnt_q+1.
    assign rvalid_o = !rf_empty;
    assign r_last   = (cnt_q == {1'b0, len_q});
    assign rlast_o  = rvalid_o && r_last;
    assign r_hs     = rvalid_o && rready_i;
    assign rf_pop   = r_hs;

    assign trans_data_o      = wf_empty ? '0 : wf_mem_q[wf_rd_q];
    assign {rdata_o, rresp_o} = rf_empty ? '0 : rf_mem_q[rf_rd_q];
    assign rid_o        = id_q;
    assign bid_o        = id_q;
    assign bvalid_o     = bvalid_q;
    assign bresp_o      = bresp_q;
    assign wr_trans_o   = wr_trans_q;
    assign rd_trans_o   = rd_trans_q;
    assign trans_addr_o = addr_q;
    assign burst_len_o  = len_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the block infers a latch.
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        len_err_d  = len_err_q;
        prio_wr_d  = prio_wr_q;
        wr_trans_d = 1'b0;
        rd_trans_d = 1'b0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        unique case (state_q)
            IDLE: begin
                if (awready_o) begin
                    {id_d, addr_d, len_d} = {awid_i, awaddr_i, awlen_i};
                    {cnt_d, err_d, len_err_d} = '0;
                    prio_wr_d = !prio_wr_q;
                    state_d   = WR_DATA;
                end else if (arready_o) begin
                    {id_d, addr_d, len_d} = {arid_i, araddr_i, arlen_i};
                    {cnt_d, err_d, len_err_d} = '0;
                    prio_wr_d  = !prio_wr_q;
                    rd_trans_d = 1'b1;
                    state_d    = RD_ISSUE;
                end
            end
            WR_DATA: begin
                if (w_hs) begin
                    if (cnt_q > {1'b0, len_q}) len_err_d = 1'b1;
                    if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
                    if (wlast_i) begin
                        if (cnt_q != {1'b0, len_q}) len_err_d = 1'b1;
                        cnt_d      = '0;
                        wr_trans_d = 1'b1;
                        state_d    = WR_ISSUE;
                    end
                end
            end
            WR_ISSUE: state_d = WR_WAIT;
            WR_WAIT: begin
                if (trans_done_i) begin
                    err_d = err_q || trans_error_i;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == {1'b0, len_q}) begin
                        bvalid_d = 1'b1;
                        bresp_d  = (err_d || len_err_q) ? 2'b10 : 2'b00;
                        state_d  = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (bready_i) begin
                    bvalid_d = 1'b0;
                    bresp_d  = 2'b00;
                    state_d  = IDLE;
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                if (r_hs) begin
                    cnt_d = cnt_q + 5'd1;
                    if (r_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wf_wr_d  = wf_push ? ptr_inc(wf_wr_q) : wf_wr_q;
        wf_rd_d  = wf_pop  ? ptr_inc(wf_rd_q) : wf_rd_q;
        wf_cnt_d = wf_cnt_q + CW'(wf_push) - CW'(wf_pop);
        // Anything the handler left unread belongs to the finished burst.
        if (b_hs) {wf_wr_d, wf_rd_d, wf_cnt_d} = '0;
        rf_wr_d  = rf_push ? ptr_inc(rf_wr_q) : rf_wr_q;
        rf_rd_d  = rf_pop  ? ptr_inc(rf_rd_q) : rf_rd_q;
        rf_cnt_d = rf_cnt_q + CW'(rf_push) - CW'(rf_pop);
        if (r_hs && r_last) {rf_wr_d, rf_rd_d, rf_cnt_d} = '0;
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            len_err_q  <= 1'b0;
            prio_wr_q  <= 1'b1;
            wr_trans_q <= 1'b0;
            rd_trans_q <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            {wf_wr_q, wf_rd_q, wf_cnt_q} <= '0;
            {rf_wr_q, rf_rd_q, rf_cnt_q} <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            len_err_q  <= len_err_d;
            prio_wr_q  <= prio_wr_d;
            wr_trans_q <= wr_trans_d;
            rd_trans_q <= rd_trans_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            {wf_wr_q, wf_rd_q, wf_cnt_q} <= {wf_wr_d, wf_rd_d, wf_cnt_d};
            {rf_wr_q, rf_rd_q, rf_cnt_q} <= {rf_wr_d, rf_rd_d, rf_cnt_d};
        end
    end

    // NOTE: storage is not reset; empty pointers gate the outputs, so stale words never escape.
    always_ff @(posedge clk) begin
        if (wf_push) wf_mem_q[wf_wr_q] <= wdata_i;
        if (rf_push) rf_mem_q[rf_wr_q] <= {read_data_i, trans_error_i ? 2'b10 : 2'b00};
    end

endmodule

// File: tb/tb_axi_slave_frontend.sv
// Directed bench for axi_slave_frontend: the bench plays AXI master and APB handler,
// drives and samples on the falling clock edge, and compares against hand-computed values.
module tb_axi_slave_frontend;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awid_i, arid_i, awlen_i, arlen_i, bid_o, rid_o, burst_len_o;
    logic [31:0] awaddr_i, araddr_i, wdata_i, rdata_o, trans_addr_o, trans_data_o, read_data_i;
    logic        awvalid_i, awready_o, wlast_i, wvalid_i, wready_o, bvalid_o, bready_i;
    logic        arvalid_i, arready_o, rlast_o, rvalid_o, rready_i;
    logic [1:0]  bresp_o, rresp_o;
    logic        wr_trans_o, rd_trans_o, fifo_rden_i, trans_done_i, trans_error_i;
    int          checks = 0;
    int          errors = 0;

    axi_slave_frontend dut (
        .clk(clk), .rst_n(rst_n),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o), .rvalid_o(rvalid_o),
        .rready_i(rready_i),
        .wr_trans_o(wr_trans_o), .rd_trans_o(rd_trans_o), .trans_addr_o(trans_addr_o),
        .burst_len_o(burst_len_o), .trans_data_o(trans_data_o), .fifo_rden_i(fifo_rden_i),
        .trans_done_i(trans_done_i), .trans_error_i(trans_error_i), .read_data_i(read_data_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic reset_dut();
        {awid_i, awaddr_i, awlen_i, awvalid_i, wdata_i, wlast_i, wvalid_i, bready_i} = '0;
        {arid_i, araddr_i, arlen_i, arvalid_i, rready_i} = '0;
        {fifo_rden_i, trans_done_i, trans_error_i, read_data_i} = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Driver tasks: start on a falling edge, return on the falling edge after the handshake.
    task automatic aw_hs(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        int n = 0;
        awid_i = id; awaddr_i = addr; awlen_i = len; awvalid_i = 1'b1;
        #1;
        while (!awready_o && n < 20) begin @(negedge clk); #1; n++; end
        if (!awready_o) begin checks++; errors++; $display("FAIL aw_timeout: awready=%b required 1", awready_o); end
        @(negedge clk);
        awvalid_i = 1'b0;
    endtask

    task automatic ar_hs(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        int n = 0;
        arid_i = id; araddr_i = addr; arlen_i = len; arvalid_i = 1'b1;
        #1;
        while (!arready_o && n < 20) begin @(negedge clk); #1; n++; end
        if (!arready_o) begin checks++; errors++; $display("FAIL ar_timeout: arready=%b required 1", arready_o); end
        @(negedge clk);
        arvalid_i = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic last);
        int n = 0;
        wdata_i = data; wlast_i = last; wvalid_i = 1'b1;
        #1;
        while (!wready_o && n < 20) begin @(negedge clk); #1; n++; end
        if (!wready_o) begin checks++; errors++; $display("FAIL w_timeout: wready=%b required 1", wready_o); end
        @(negedge clk);
        wvalid_i = 1'b0; wlast_i = 1'b0;
    endtask

    task automatic wr_done(input logic err, input logic pop);
        trans_done_i = 1'b1; trans_error_i = err; fifo_rden_i = pop;
        @(negedge clk);
        trans_done_i = 1'b0; trans_error_i = 1'b0; fifo_rden_i = 1'b0;
    endtask

    task automatic b_hs();
        int n = 0;
        while (!bvalid_o && n < 20) begin @(negedge clk); n++; end
        if (!bvalid_o) begin checks++; errors++; $display("FAIL b_timeout: bvalid=%b required 1", bvalid_o); end
        bready_i = 1'b1;
        @(negedge clk);
        bready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if ({awready_o, arready_o, wready_o, bvalid_o, rvalid_o, rlast_o, wr_trans_o, rd_trans_o} !== 8'h00)
            begin errors++; $display("FAIL reset_ctrl: got %b required 00000000",
                {awready_o, arready_o, wready_o, bvalid_o, rvalid_o, rlast_o, wr_trans_o, rd_trans_o}); end
        checks++; if (trans_data_o !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h required 0", trans_data_o); end
        checks++; if ({trans_addr_o, burst_len_o} !== 36'h0)
            begin errors++; $display("FAIL reset_taddr: got %h/%h required 0/0", trans_addr_o, burst_len_o); end
        checks++; if ({bid_o, bresp_o, rid_o, rdata_o, rresp_o} !== 44'h0)
            begin errors++; $display("FAIL reset_resp: bid %h bresp %b rid %h rdata %h rresp %b required all 0",
                bid_o, bresp_o, rid_o, rdata_o, rresp_o); end
    endtask

    task automatic test_single_write();
        aw_hs(4'h3, 32'h0001_F000, 4'd0);
        w_beat(32'hA5A5_0001, 1'b1);
        checks++; if (wr_trans_o !== 1'b1) begin errors++; $display("FAIL single_wr_trans: got %b required 1", wr_trans_o); end
        checks++; if (trans_addr_o !== 32'h0001_F000 || burst_len_o !== 4'd0)
            begin errors++; $display("FAIL single_addr: got %h/%h required 0001f000/0", trans_addr_o, burst_len_o); end
        checks++; if (trans_data_o !== 32'hA5A5_0001)
            begin errors++; $display("FAIL single_head: got %h required a5a50001", trans_data_o); end
        @(negedge clk);
        checks++; if (wr_trans_o !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b required 0", wr_trans_o); end
        wr_done(1'b0, 1'b1);
        checks++; if (bvalid_o !== 1'b1 || bresp_o !== 2'b00 || bid_o !== 4'h3)
            begin errors++; $display("FAIL single_b: bvalid %b bresp %b bid %h required 1/00/3", bvalid_o, bresp_o, bid_o); end
        b_hs();
        checks++; if (bvalid_o !== 1'b0) begin errors++; $display("FAIL single_b_drop: got %b required 0", bvalid_o); end
    endtask

    task automatic test_burst_write();
        aw_hs(4'h5, 32'h0000_0100, 4'd3);
        for (int i = 1; i <= 4; i++) w_beat(32'(i), i == 4);
        checks++; if (wr_trans_o !== 1'b1) begin errors++; $display("FAIL burst_latency: wr_trans %b required 1", wr_trans_o); end
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            checks++; if (trans_data_o !== 32'(i))
                begin errors++; $display("FAIL burst_data: beat %0d got %h required %h", i, trans_data_o, 32'(i)); end
            if (i == 4) begin
                checks++; if (bvalid_o !== 1'b0) begin errors++; $display("FAIL burst_early_b: got %b required 0", bvalid_o); end
            end
            wr_done(i == 2, 1'b1);
        end
        checks++; if (bvalid_o !== 1'b1 || bresp_o !== 2'b10 || bid_o !== 4'h5)
            begin errors++; $display("FAIL burst_b: bvalid %b bresp %b bid %h required 1/10/5", bvalid_o, bresp_o, bid_o); end
        b_hs();
    endtask

    task automatic test_excess_write();
        aw_hs(4'h6, 32'h0000_0200, 4'd1);
        w_beat(32'h31, 1'b0); w_beat(32'h32, 1'b0); w_beat(32'h33, 1'b1);
        checks++; if (wr_trans_o !== 1'b1) begin errors++; $display("FAIL excess_wr_trans: got %b required 1", wr_trans_o); end
        @(negedge clk);
        checks++; if (trans_data_o !== 32'h31) begin errors++; $display("FAIL excess_head0: got %h required 31", trans_data_o); end
        wr_done(1'b0, 1'b1);
        checks++; if (trans_data_o !== 32'h32) begin errors++; $display("FAIL excess_head1: got %h required 32", trans_data_o); end
        wr_done(1'b0, 1'b0);
        checks++; if (bvalid_o !== 1'b1 || bresp_o !== 2'b10)
            begin errors++; $display("FAIL excess_b: bvalid %b bresp %b required 1/10", bvalid_o, bresp_o); end
        b_hs();
        checks++; if (trans_data_o !== 32'h0) begin errors++; $display("FAIL excess_flush: got %h required 0", trans_data_o); end
    endtask

    task automatic test_short_write();
        logic [31:0] exp_head [4] = '{32'h11, 32'h22, 32'h0, 32'h0};
        aw_hs(4'h7, 32'h0000_0300, 4'd3);
        w_beat(32'h11, 1'b0); w_beat(32'h22, 1'b1);
        checks++; if (wr_trans_o !== 1'b1) begin errors++; $display("FAIL short_wr_trans: got %b required 1", wr_trans_o); end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++; if (trans_data_o !== exp_head[i])
                begin errors++; $display("FAIL short_head: beat %0d got %h required %h", i, trans_data_o, exp_head[i]); end
            wr_done(1'b0, 1'b1);
        end
        checks++; if (bvalid_o !== 1'b1 || bresp_o !== 2'b10 || bid_o !== 4'h7)
            begin errors++; $display("FAIL short_b: bvalid %b bresp %b bid %h required 1/10/7", bvalid_o, bresp_o, bid_o); end
        b_hs();
        checks++; if (trans_data_o !== 32'h0 || bvalid_o !== 1'b0)
            begin errors++; $display("FAIL short_after: tdata %h bvalid %b required 0/0", trans_data_o, bvalid_o); end
    endtask

    task automatic test_read_burst();
        int k = 0;
        int c = 0;
        ar_hs(4'h9, 32'h0002_F000, 4'd15);
        checks++; if (rd_trans_o !== 1'b1 || trans_addr_o !== 32'h0002_F000 || burst_len_o !== 4'd15)
            begin errors++; $display("FAIL read_issue: rd_trans %b addr %h len %h required 1/0002f000/f",
                rd_trans_o, trans_addr_o, burst_len_o); end
        @(negedge clk);
        checks++; if (rd_trans_o !== 1'b0) begin errors++; $display("FAIL read_pulse: got %b required 0", rd_trans_o); end
        while (k < 16 && c < 80) begin
            trans_done_i  = (c < 16);
            read_data_i   = 32'hD000_0000 + 32'(c);
            trans_error_i = (c == 4);
            rready_i      = (c >= 10);
            #1;
            if (c == 9) begin
                checks++; if (rvalid_o !== 1'b1 || rdata_o !== 32'hD000_0000 || rlast_o !== 1'b0)
                    begin errors++; $display("FAIL read_stall_hold: rvalid %b rdata %h rlast %b required 1/d0000000/0",
                        rvalid_o, rdata_o, rlast_o); end
            end
            if (rvalid_o && rready_i) begin
                checks++; if (rdata_o !== 32'hD000_0000 + 32'(k) || rresp_o !== ((k == 4) ? 2'b10 : 2'b00) ||
                              rlast_o !== (k == 15) || rid_o !== 4'h9)
                    begin errors++; $display("FAIL read_beat: beat %0d rdata %h rresp %b rlast %b rid %h required %h/%b/%b/9",
                        k, rdata_o, rresp_o, rlast_o, rid_o, 32'hD000_0000 + 32'(k), (k == 4) ? 2'b10 : 2'b00, k == 15); end
                k++;
            end
            @(negedge clk);
            c++;
        end
        trans_done_i = 1'b0; trans_error_i = 1'b0; rready_i = 1'b0;
        checks++; if (k !== 16) begin errors++; $display("FAIL read_count: got %0d beats required 16", k); end
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL read_drained: rvalid %b required 0", rvalid_o); end
    endtask

    task automatic test_arbitration();
        logic exp_wr;
        int   n;
        reset_dut();
        for (int r = 0; r < 3; r++) begin
            exp_wr = (r != 1);
            awid_i = 4'h1; awaddr_i = 32'h0000_0400; awlen_i = 4'd0;
            arid_i = 4'h2; araddr_i = 32'h0000_0500; arlen_i = 4'd0;
            awvalid_i = 1'b1; arvalid_i = 1'b1;
            #1;
            checks++; if (awready_o !== exp_wr || arready_o !== !exp_wr)
                begin errors++; $display("FAIL arb_grant: round %0d awready %b arready %b required %b/%b",
                    r, awready_o, arready_o, exp_wr, !exp_wr); end
            @(negedge clk);
            awvalid_i = 1'b0; arvalid_i = 1'b0;
            if (exp_wr) begin
                w_beat(32'hB0 + 32'(r), 1'b1);
                @(negedge clk);
                wr_done(1'b0, 1'b1);
                b_hs();
            end else begin
                @(negedge clk);
                trans_done_i = 1'b1; read_data_i = 32'h0000_00C0;
                @(negedge clk);
                trans_done_i = 1'b0;
                checks++; if (rvalid_o !== 1'b1 || rlast_o !== 1'b1 || rdata_o !== 32'hC0 || rid_o !== 4'h2)
                    begin errors++; $display("FAIL arb_read: rvalid %b rlast %b rdata %h rid %h required 1/1/000000c0/2",
                        rvalid_o, rlast_o, rdata_o, rid_o); end
                rready_i = 1'b1;
                n = 0;
                #1;
                while (!rvalid_o && n < 20) begin @(negedge clk); #1; n++; end
                @(negedge clk);
                rready_i = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_read();
        ar_hs(4'hA, 32'h0002_0000, 4'd7);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            trans_done_i = 1'b1; read_data_i = 32'hE0 + 32'(i);
            @(negedge clk);
        end
        trans_done_i = 1'b0;
        checks++; if (rvalid_o !== 1'b1 || rdata_o !== 32'hE0)
            begin errors++; $display("FAIL midrd_buffered: rvalid %b rdata %h required 1/000000e0", rvalid_o, rdata_o); end
        rst_n = 1'b0;
        #1;
        checks++; if ({rvalid_o, rlast_o, rid_o, rdata_o, rresp_o, trans_addr_o, burst_len_o} !== 76'h0)
            begin errors++; $display("FAIL midrd_reset_r: rvalid %b rlast %b rid %h rdata %h rresp %b addr %h len %h required all 0",
                rvalid_o, rlast_o, rid_o, rdata_o, rresp_o, trans_addr_o, burst_len_o); end
        checks++; if ({awready_o, arready_o, wready_o, bvalid_o, wr_trans_o, rd_trans_o, bresp_o, bid_o} !== 12'h0)
            begin errors++; $display("FAIL midrd_reset_ctrl: got %b required all 0",
                {awready_o, arready_o, wready_o, bvalid_o, wr_trans_o, rd_trans_o, bresp_o, bid_o}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        awvalid_i = 1'b1;
        #1;
        checks++; if (awready_o !== 1'b1) begin errors++; $display("FAIL midrd_idle: awready %b required 1", awready_o); end
        aw_hs(4'h2, 32'h0000_0600, 4'd0);
        w_beat(32'h0000_00F1, 1'b1);
        checks++; if (wr_trans_o !== 1'b1 || trans_data_o !== 32'hF1)
            begin errors++; $display("FAIL midrd_write: wr_trans %b tdata %h required 1/000000f1", wr_trans_o, trans_data_o); end
        @(negedge clk);
        wr_done(1'b0, 1'b1);
        checks++; if (bvalid_o !== 1'b1 || bresp_o !== 2'b00 || bid_o !== 4'h2)
            begin errors++; $display("FAIL midrd_b: bvalid %b bresp %b bid %h required 1/00/2", bvalid_o, bresp_o, bid_o); end
        b_hs();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_write();
        test_excess_write();
        test_short_write();
        test_read_burst();
        test_arbitration();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
